jump_branch_unit: RTL and testbench

//  Parametrised control-transfer execute unit covering JAL, JALR and conditional branches (BEQ..BGEU).

---
 rtl/jump_branch_unit.sv | 199 +++++++++++++++++++
 tb/tb_jump_branch_unit.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jump_branch_unit.sv
// jump_branch_unit
//   Execute-stage control-transfer unit for JAL, JALR and conditional branches.
//   Computes link value, next PC, taken flag and per-result errors, staged in a
//   1-deep valid/ready output register. Keeps a return-address stack (RAS) and
//   flags JALR return mispredictions.
// Ports
//   clk, reset                 clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready        request handshake (in_ready is combinational)
//   op_kind, subfunction_3     0=JAL 1=JALR 2=BRANCH 3=reserved, funct3
//   program_counter, input_register1_value, input_register2_value, immediate
//   rd_index, rs1_index        register indices (write enable, RAS link hints)
//   flush                      discard the staged result
//   out_valid / out_ready      result handshake
//   result_to_write_rd, write_rd_enable, result_to_write_to_pc, take_jump,
//   decoding_error, misaligned_error, ras_prediction_valid, ras_mispredict
module jump_branch_unit #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned IALIGN    = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op_kind,
  input  logic [2:0]      subfunction_3,
  input  logic [XLEN-1:0] program_counter,
  input  logic [XLEN-1:0] input_register1_value,
  input  logic [XLEN-1:0] input_register2_value,
  input  logic [XLEN-1:0] immediate,
  input  logic [4:0]      rd_index,
  input  logic [4:0]      rs1_index,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result_to_write_rd,
  output logic            write_rd_enable,
  output logic [XLEN-1:0] result_to_write_to_pc,
  output logic            take_jump,
  output logic            decoding_error,
  output logic            misaligned_error,
  output logic            ras_prediction_valid,
  output logic            ras_mispredict
);

  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  typedef enum logic [1:0] {
    OP_JAL    = 2'd0,
    OP_JALR   = 2'd1,
    OP_BRANCH = 2'd2,
    OP_RSV    = 2'd3
  } op_kind_e;

  op_kind_e        w_op;
  logic            w_accept;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_target;
  logic            w_cond;
  logic            w_dec_err;
  logic            w_misaligned;
  logic            w_err;
  logic            w_taken;
  logic            w_is_jump;
  logic            w_rd_link;
  logic            w_rs1_link;
  logic            w_do_push;
  logic            w_do_pop;
  logic            w_pred_valid;
  logic            w_mispredict;
  logic [PTR_W-1:0] w_top_idx;
  logic [PTR_W-1:0] w_next_ptr;

  logic [XLEN-1:0]  r_ras [RAS_DEPTH];
  logic [PTR_W-1:0] r_ras_ptr;
  logic [CNT_W-1:0] r_ras_cnt;

  logic            r_out_valid;
  logic [XLEN-1:0] r_link;
  logic            r_wr_en;
  logic [XLEN-1:0] r_next_pc;
  logic            r_take;
  logic            r_dec_err;
  logic            r_mis_err;
  logic            r_pred_valid;
  logic            r_mispredict;

  assign w_op       = op_kind_e'(op_kind);
  assign in_ready   = !flush && (!r_out_valid || out_ready);
  assign w_accept   = in_valid && in_ready;
  assign w_pc_plus4 = program_counter + XLEN'(4);

  // Target selection, branch condition and decode legality
  always_comb begin
    w_target  = program_counter + immediate;
    w_cond    = 1'b0;
    w_dec_err = 1'b0;
    unique case (w_op)
      OP_JAL:  w_cond = 1'b1;
      OP_JALR: begin
        w_target  = (input_register1_value + immediate) & ~XLEN'(1);
        w_cond    = 1'b1;
        w_dec_err = (subfunction_3 != 3'b000);
      end
      OP_BRANCH: begin
        case (subfunction_3)
          3'b000:  w_cond = (input_register1_value == input_register2_value);
          3'b001:  w_cond = (input_register1_value != input_register2_value);
          3'b100:  w_cond = ($signed(input_register1_value) <  $signed(input_register2_value));
          3'b101:  w_cond = ($signed(input_register1_value) >= $signed(input_register2_value));
          3'b110:  w_cond = (input_register1_value <  input_register2_value);
          3'b111:  w_cond = (input_register1_value >= input_register2_value);
          default: w_dec_err = 1'b1;
        endcase
      end
      default: w_dec_err = 1'b1;
    endcase
  end

  // Misalignment only matters for a transfer that would actually be taken
  assign w_misaligned = (IALIGN == 32) && w_cond && !w_dec_err && w_target[1];
  assign w_err        = w_dec_err || w_misaligned;
  assign w_taken      = w_cond && !w_err;
  assign w_is_jump    = (w_op == OP_JAL) || (w_op == OP_JALR);

  // RAS hints: x1/x5 are link registers
  assign w_rd_link  = (rd_index == 5'd1) || (rd_index == 5'd5);
  assign w_rs1_link = (rs1_index == 5'd1) || (rs1_index == 5'd5);
  assign w_do_push  = w_accept && w_is_jump && !w_err && w_rd_link;
  assign w_do_pop   = w_accept && (w_op == OP_JALR) && !w_err && w_rs1_link &&
                      (!w_rd_link || (rd_index != rs1_index));

  assign w_top_idx  = (r_ras_ptr == '0) ? PTR_W'(RAS_DEPTH - 1) : r_ras_ptr - PTR_W'(1);
  assign w_next_ptr = (r_ras_ptr == PTR_W'(RAS_DEPTH - 1)) ? '0 : r_ras_ptr + PTR_W'(1);

  assign w_pred_valid = w_do_pop && (r_ras_cnt != '0);
  assign w_mispredict = w_pred_valid && (r_ras[w_top_idx] != w_target);

  // Circular RAS; a pop-then-push replaces the top entry in place
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(RAS_DEPTH); i++) r_ras[i] <= '0;
      r_ras_ptr <= '0;
      r_ras_cnt <= '0;
    end else if (w_pred_valid) begin
      if (w_do_push) begin
        r_ras[w_top_idx] <= w_pc_plus4;
      end else begin
        r_ras_ptr <= w_top_idx;
        r_ras_cnt <= r_ras_cnt - CNT_W'(1);
      end
    end else if (w_do_push) begin
      r_ras[r_ras_ptr] <= w_pc_plus4;
      r_ras_ptr        <= w_next_ptr;
      if (r_ras_cnt != CNT_W'(RAS_DEPTH)) r_ras_cnt <= r_ras_cnt + CNT_W'(1);
    end
  end

  // 1-deep output stage; flush wins over a pending consume
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid  <= 1'b0;
      r_link       <= '0;
      r_wr_en      <= 1'b0;
      r_next_pc    <= '0;
      r_take       <= 1'b0;
      r_dec_err    <= 1'b0;
      r_mis_err    <= 1'b0;
      r_pred_valid <= 1'b0;
      r_mispredict <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid  <= 1'b1;
      r_link       <= w_pc_plus4;
      r_wr_en      <= w_is_jump && !w_err && (rd_index != 5'd0);
      r_next_pc    <= w_taken ? w_target : w_pc_plus4;
      r_take       <= w_taken;
      r_dec_err    <= w_dec_err;
      r_mis_err    <= w_misaligned;
      r_pred_valid <= w_pred_valid;
      r_mispredict <= w_mispredict;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid             = r_out_valid;
  assign result_to_write_rd    = r_link;
  assign write_rd_enable       = r_wr_en;
  assign result_to_write_to_pc = r_next_pc;
  assign take_jump             = r_take;
  assign decoding_error        = r_dec_err;
  assign misaligned_error      = r_mis_err;
  assign ras_prediction_valid  = r_pred_valid;
  assign ras_mispredict        = r_mispredict;

endmodule

// File: tb/tb_jump_branch_unit.sv
// tb_jump_branch_unit
//   Directed and randomized stimulus for jump_branch_unit, checked against a
//   behavioural model (RAS as a bounded queue, staged result as a record).
module tb_jump_branch_unit;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned IALIGN    = 32;
  localparam int unsigned RAS_DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [1:0]      op_kind = '0;
  logic [2:0]      subfunction_3 = '0;
  logic [XLEN-1:0] program_counter = '0;
  logic [XLEN-1:0] input_register1_value = '0;
  logic [XLEN-1:0] input_register2_value = '0;
  logic [XLEN-1:0] immediate = '0;
  logic [4:0]      rd_index = '0;
  logic [4:0]      rs1_index = '0;
  logic            flush = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [XLEN-1:0] result_to_write_rd;
  logic            write_rd_enable;
  logic [XLEN-1:0] result_to_write_to_pc;
  logic            take_jump;
  logic            decoding_error;
  logic            misaligned_error;
  logic            ras_prediction_valid;
  logic            ras_mispredict;

  jump_branch_unit #(.XLEN(XLEN), .IALIGN(IALIGN), .RAS_DEPTH(RAS_DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op_kind(op_kind), .subfunction_3(subfunction_3),
    .program_counter(program_counter),
    .input_register1_value(input_register1_value),
    .input_register2_value(input_register2_value),
    .immediate(immediate), .rd_index(rd_index), .rs1_index(rs1_index),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .result_to_write_rd(result_to_write_rd), .write_rd_enable(write_rd_enable),
    .result_to_write_to_pc(result_to_write_to_pc), .take_jump(take_jump),
    .decoding_error(decoding_error), .misaligned_error(misaligned_error),
    .ras_prediction_valid(ras_prediction_valid), .ras_mispredict(ras_mispredict)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] link;
    logic [31:0] pc;
    logic        wr;
    logic        take;
    logic        dec;
    logic        mis;
    logic        pv;
    logic        mp;
  } res_t;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [31:0] ras[$];
  logic        m_valid = 1'b0;
  res_t        m_res = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic is_link(input logic [4:0] idx);
    return (idx == 5'd1) || (idx == 5'd5);
  endfunction

  // Reference result for the request currently on the inputs; updates the RAS model
  function automatic res_t model();
    res_t r;
    logic [31:0] tgt, pc4, popped;
    logic cond, dec, mis;
    r = '0;
    pc4 = program_counter + 32'd4;
    r.link = pc4;
    tgt = program_counter + immediate;
    cond = 1'b0;
    dec = 1'b0;
    if (op_kind == 2'd0) cond = 1'b1;
    else if (op_kind == 2'd1) begin
      tgt = (input_register1_value + immediate) & 32'hFFFF_FFFE;
      cond = 1'b1;
      dec = (subfunction_3 != 3'd0);
    end else if (op_kind == 2'd2) begin
      case (subfunction_3)
        3'd0: cond = input_register1_value == input_register2_value;
        3'd1: cond = input_register1_value != input_register2_value;
        3'd4: cond = $signed(input_register1_value) < $signed(input_register2_value);
        3'd5: cond = $signed(input_register1_value) >= $signed(input_register2_value);
        3'd6: cond = input_register1_value < input_register2_value;
        3'd7: cond = input_register1_value >= input_register2_value;
        default: dec = 1'b1;
      endcase
    end else dec = 1'b1;
    mis = !dec && cond && (IALIGN == 32) && tgt[1];
    r.dec = dec;
    r.mis = mis;
    if (dec || mis) begin
      r.pc = pc4;
      return r;
    end
    r.take = cond;
    r.pc = cond ? tgt : pc4;
    if (op_kind == 2'd0 || op_kind == 2'd1) begin
      r.wr = (rd_index != 5'd0);
      if (op_kind == 2'd1 && is_link(rs1_index) &&
          !(is_link(rd_index) && rd_index == rs1_index) && ras.size() > 0) begin
        popped = ras.pop_back();
        r.pv = 1'b1;
        r.mp = (popped != tgt);
      end
      if (is_link(rd_index)) begin
        ras.push_back(pc4);
        if (ras.size() > RAS_DEPTH) void'(ras.pop_front());
      end
    end
    return r;
  endfunction

  // One clock: inputs were set at the preceding negedge
  task automatic cycle();
    logic exp_rdy, acc;
    exp_rdy = !flush && (!m_valid || out_ready);
    #1;
    check("in_ready", in_ready, exp_rdy);
    acc = in_valid && exp_rdy;
    @(posedge clk);
    if (flush) m_valid = 1'b0;
    else if (acc) begin
      m_res = model();
      m_valid = 1'b1;
    end else if (out_ready) m_valid = 1'b0;
    @(negedge clk);
    check("out_valid", out_valid, m_valid);
    if (m_valid) begin
      check("rd_value", result_to_write_rd, m_res.link);
      check("next_pc", result_to_write_to_pc, m_res.pc);
      check("wr_en", write_rd_enable, m_res.wr);
      check("take", take_jump, m_res.take);
      check("dec_err", decoding_error, m_res.dec);
      check("mis_err", misaligned_error, m_res.mis);
      check("ras_pv", ras_prediction_valid, m_res.pv);
      check("ras_mp", ras_mispredict, m_res.mp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] pc,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                       input logic [4:0] rd, input logic [4:0] rs1);
    in_valid = 1'b1;
    op_kind = op;
    subfunction_3 = f3;
    program_counter = pc;
    input_register1_value = a;
    input_register2_value = b;
    immediate = imm;
    rd_index = rd;
    rs1_index = rs1;
    cycle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m_valid = 1'b0;
    ras.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [4:0] pick_idx();
    case ($urandom_range(0, 3))
      0: return 5'd0;
      1: return 5'd1;
      2: return 5'd5;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  initial begin
    #2 reset = 1'b1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_pc", result_to_write_to_pc, 0);
    check("rst_rd", result_to_write_rd, 0);
    check("rst_take", take_jump, 0);
    check("rst_flags", {write_rd_enable, decoding_error, misaligned_error,
                        ras_prediction_valid, ras_mispredict}, 0);
    check("rst_in_ready", in_ready, 1);
    reset = 1'b0;

    // JAL with link push
    drive(2'd0, 3'd0, 32'h100, 0, 0, 32'h20, 5'd1, 5'd0);
    check("jal_pc", result_to_write_to_pc, 32'h120);
    check("jal_rd", result_to_write_rd, 32'h104);
    check("jal_wr", write_rd_enable, 1);
    check("jal_take", take_jump, 1);
    // Push 0x1004, then a JALR return to a different place
    drive(2'd0, 3'd0, 32'h1000, 0, 0, 32'h100, 5'd1, 5'd0);
    drive(2'd1, 3'd0, 32'h2000, 32'h1001, 0, 32'h0, 5'd0, 5'd1);
    check("jalr_pc", result_to_write_to_pc, 32'h1000);
    check("jalr_pv", ras_prediction_valid, 1);
    check("jalr_mp", ras_mispredict, 1);
    // Branch conditions
    drive(2'd2, 3'd4, 32'h300, 32'hFFFF_FFFF, 32'h1, 32'h40, 5'd0, 5'd0);
    check("blt_take", take_jump, 1);
    drive(2'd2, 3'd6, 32'h300, 32'hFFFF_FFFF, 32'h1, 32'h40, 5'd0, 5'd0);
    check("bltu_take", take_jump, 0);
    check("bltu_pc", result_to_write_to_pc, 32'h304);
    drive(2'd2, 3'd2, 32'h300, 32'h5, 32'h5, 32'h40, 5'd0, 5'd0);
    check("f3_010_dec", decoding_error, 1);
    check("f3_010_take", take_jump, 0);
    // Misaligned JAL and wrap-around target
    drive(2'd0, 3'd0, 32'h100, 0, 0, 32'h2, 5'd1, 5'd0);
    check("jal_mis", misaligned_error, 1);
    check("jal_mis_wr", write_rd_enable, 0);
    drive(2'd0, 3'd0, 32'hFFFF_FFFC, 0, 0, 32'h8, 5'd0, 5'd0);
    check("wrap_pc", result_to_write_to_pc, 32'h4);

    // Back-pressure then flush
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(2'd2, 3'd0, 32'h500, 1, 1, 32'h10, 5'd0, 5'd0);
      check("bp_hold_pc", result_to_write_to_pc, 32'h4);
    end
    flush = 1'b1;
    cycle();
    check("flush_ov", out_valid, 0);
    flush = 1'b0;
    out_ready = 1'b1;

    // Async reset mid-operation
    drive(2'd0, 3'd0, 32'h600, 0, 0, 32'h8, 5'd1, 5'd0);
    reset = 1'b1;
    #1;
    check("async_rst_ov", out_valid, 0);
    do_reset();

    // RAS overflow: RAS_DEPTH+1 pushes, then RAS_DEPTH+1 pops
    for (int i = 0; i <= int'(RAS_DEPTH); i++)
      drive(2'd0, 3'd0, 32'h2000 + 32'(i) * 32'h100, 0, 0, 32'h40, 5'd1, 5'd0);
    for (int k = 0; k <= int'(RAS_DEPTH); k++) begin
      drive(2'd1, 3'd0, 32'h8000, 32'h2004 + 32'(int'(RAS_DEPTH) - k) * 32'h100, 0, 0, 5'd0, 5'd5);
      if (k == 0) check("ras_first_pv", ras_prediction_valid, 1);
      if (k == 0) check("ras_first_mp", ras_mispredict, 0);
      if (k == int'(RAS_DEPTH)) check("ras_empty_pv", ras_prediction_valid, 0);
    end

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [2:0] sel;
      sel = 3'($urandom_range(0, 7));
      in_valid = ($urandom_range(0, 9) < 8);
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 15) == 0);
      op_kind = (sel < 2) ? 2'd0 : (sel < 4) ? 2'd1 : (sel < 7) ? 2'd2 : 2'd3;
      subfunction_3 = (op_kind == 2'd1 && $urandom_range(0, 4) != 0) ? 3'd0
                      : 3'($urandom_range(0, 7));
      program_counter = $urandom() & 32'hFFFF_FFFC;
      immediate = ($urandom_range(0, 3) == 0) ? $urandom() : (32'($signed(12'($urandom()))) & ~32'h3);
      input_register1_value = $urandom();
      input_register2_value = ($urandom_range(0, 3) == 0) ? input_register1_value : $urandom();
      if (ras.size() > 0 && $urandom_range(0, 1) == 1) begin
        input_register1_value = ras[$] - immediate;
        if ($urandom_range(0, 3) == 0) input_register1_value += 32'd8;
      end
      rd_index = pick_idx();
      rs1_index = pick_idx();
      cycle();
    end

    in_valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
